// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder
package sha256_pkg;
    typedef enum logic [1:0] {ABSORB, PAD, LEN, EMIT} state_t;
    localparam int BLOCK_BYTES = 64;
    localparam int LEN_OFFSET = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    typedef logic [8*BLOCK_BYTES-1:0] block_t;
endpackage

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a byte stream big-endian into 512-bit blocks with FIPS 180-4 padding
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   din,
    input  logic         valid,
    input  logic         last,
    output logic         ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    output logic         blk_first,
    output logic         blk_final,
    input  logic         blk_ready
);
    state_t           state;
    block_t           blk;
    logic [5:0]       idx;
    logic [LEN_W-1:0] bitlen;
    logic             need_len;
    logic             pend_last;

    assign ready     = state == ABSORB;
    assign blk_valid = state == EMIT;
    assign blk_data  = blk;

    // byte idx occupies bits {~idx,3'b0} +: 8, so byte 0 lands in [511:504]
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= ABSORB;
            blk       <= '0;
            idx       <= '0;
            bitlen    <= '0;
            need_len  <= 1'b0;
            pend_last <= 1'b0;
            blk_first <= 1'b1;
            blk_final <= 1'b0;
        end else begin
            case (state)
                ABSORB: if (valid) begin
                    blk[{~idx, 3'b000} +: 8] <= din;
                    bitlen <= bitlen + LEN_W'(8);
                    idx <= idx + 6'd1;
                    if (idx == 6'(BLOCK_BYTES - 1)) begin
                        pend_last <= last;
                        state <= EMIT;
                    end else if (last)
                        state <= PAD;
                end
                PAD: begin
                    for (int i = 0; i < BLOCK_BYTES; i++)
                        if (i > int'(idx)) blk[8*(BLOCK_BYTES-1-i) +: 8] <= '0;
                    blk[{~idx, 3'b000} +: 8] <= PAD_BYTE;
                    if (int'(idx) < LEN_OFFSET) begin
                        blk[LEN_W-1:0] <= bitlen;
                        blk_final <= 1'b1;
                    end else
                        need_len <= 1'b1;
                    state <= EMIT;
                end
                LEN: begin
                    blk <= block_t'(bitlen);
                    blk_final <= 1'b1;
                    need_len <= 1'b0;
                    state <= EMIT;
                end
                EMIT: if (blk_ready) begin
                    blk <= '0;
                    idx <= '0;
                    blk_first <= blk_final;
                    blk_final <= 1'b0;
                    if (need_len)
                        state <= LEN;
                    else if (pend_last) begin
                        pend_last <= 1'b0;
                        state <= PAD;
                    end else begin
                        if (blk_final) bitlen <= '0;
                        state <= ABSORB;
                    end
                end
                default: state <= ABSORB;
            endcase
        end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: randomized bench against a byte-level padding model
module tb_sha256_msg_padder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   din = '0;
    logic         valid = 1'b0;
    logic         last = 1'b0;
    logic         ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_first;
    logic         blk_final;
    logic         blk_ready = 1'b0;

    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] msg[$];
    logic [7:0] pb[$];
    logic [511:0] first_blk;

    sha256_msg_padder dut (
        .clk(clk), .rst(rst), .din(din), .valid(valid), .last(last), .ready(ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_first(blk_first),
        .blk_final(blk_final), .blk_ready(blk_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // padded byte stream: message, 0x80, zeros to 56 mod 64, 64-bit bit length
    function automatic void pad_model();
        logic [63:0] len;
        pb = msg;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        len = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) pb.push_back(len[8*k +: 8]);
    endfunction

    function automatic logic [511:0] blk_of(input int k);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*(63-i) +: 8] = pb[64*k+i];
        return r;
    endfunction

    task automatic run_msg(input int pv, input int pr);
        int n, nb, pos, blk, cyc, t_last, t_valid;
        pad_model();
        n = msg.size();
        nb = pb.size() / 64;
        pos = 0; blk = 0; cyc = 0; t_last = -1; t_valid = -1;
        while ((pos < n || blk < nb) && cyc < 5000) begin
            if (blk_valid && t_last >= 0 && t_valid < 0) t_valid = cyc;
            valid = pos < n && $urandom_range(99) < pv;
            din = pos < n ? msg[pos] : 8'h00;
            last = pos == n - 1;
            blk_ready = $urandom_range(99) < pr;
            if (blk_valid && blk_ready) begin
                check("blk_data", blk_data, blk_of(blk));
                check("blk_first", blk_first, blk == 0);
                check("blk_final", blk_final, blk == nb - 1);
                if (blk == 0) first_blk = blk_data;
                blk++;
            end
            if (valid && ready) begin
                pos++;
                if (pos == n) t_last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        valid = 1'b0; last = 1'b0; blk_ready = 1'b0;
        check("msg_done", cyc < 5000, 1);
        check("latency", t_valid - t_last, n % 64 == 0 ? 1 : 2);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_valid", blk_valid, 0);
        check("rst_data", blk_data, 0);
        check("rst_first", blk_first, 1);
        check("rst_final", blk_final, 0);
        rst = 1'b0;
        @(negedge clk);

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(100, 100);
        check("abc_block", first_blk, ABC);

        msg.delete();
        repeat (55) msg.push_back(8'h00);
        run_msg(100, 100);
        check("len55", first_blk[63:0], 64'h1B8);

        msg.delete();
        repeat (56) msg.push_back(8'($urandom));
        run_msg(100, 100);
        msg.delete();
        repeat (64) msg.push_back(8'($urandom));
        run_msg(100, 100);

        msg.delete();
        repeat (64) msg.push_back(8'($urandom));
        msg.push_back(8'h5a);
        pad_model();
        for (int i = 0; i < 64; i++) begin
            valid = 1'b1; din = msg[i]; last = 1'b0; blk_ready = 1'b0;
            @(negedge clk);
        end
        din = msg[64]; last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", blk_valid, 1);
            check("bp_ready", ready, 0);
            check("bp_data", blk_data, blk_of(0));
            @(negedge clk);
        end
        check("bp_first", blk_first, 1);
        check("bp_final", blk_final, 0);
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        check("bp_resume", ready, 1);
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
        @(negedge clk);
        check("bp_blk2", blk_data, blk_of(1));
        check("bp_blk2_first", blk_first, 0);
        check("bp_blk2_final", blk_final, 1);
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        check("bp_idle", ready, 1);

        for (int i = 0; i < 20; i++) begin
            valid = 1'b1; din = 8'($urandom); last = 1'b0;
            @(negedge clk);
        end
        valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", ready, 1);
        check("rst_mid_first", blk_first, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            valid = 1'b1; din = 8'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        check("rst_pre_valid", blk_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", blk_valid, 0);
        check("rst_async_data", blk_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(100, 100);
        check("rst_abc_block", first_blk, ABC);

        for (int t = 0; t < 20; t++) begin
            int n;
            msg.delete();
            n = $urandom_range(1, 150);
            repeat (n) msg.push_back(8'($urandom));
            run_msg($urandom_range(40, 100), $urandom_range(30, 100));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
